uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1, clocks per serial bit; legal range 1..65535. HALF = (CLKS_PER_BIT-1)/2, integer division.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: rx  input  1  serial line, idle high; 8N1 frame = start(0), 8 data bits LSB first, stop(1).
REQ-005 Port: rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1.
REQ-006 Port: rx_data  output  8  received byte, held stable while rx_valid=1.
REQ-007 Port: rx_valid  output  1  byte available; stays high until accepted.
REQ-008 Port: busy  output  1  high while state != IDLE.
REQ-009 Port: frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-010 Port: overrun  output  1  one-cycle pulse, new byte arrived while holding register still full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-012 States SHALL be IDLE, START, DATA, STOP; bit counter cnt sized for CLKS_PER_BIT-1; bit_idx 3 bits.
REQ-013 IDLE: rx_s=0 -> START with cnt=1; if HALF=0 -> DATA directly with cnt=0, bit_idx=0.
REQ-014 START: when cnt=HALF, rx_s=0 -> DATA with cnt=0, bit_idx=0; rx_s=1 -> IDLE (glitch, no output change); else cnt+1.
REQ-015 DATA: when cnt=CLKS_PER_BIT-1, shift_reg[bit_idx] <= rx_s, cnt=0; bit_idx=7 -> STOP, else bit_idx+1; otherwise cnt+1.
REQ-016 STOP: when cnt=CLKS_PER_BIT-1, sample rx_s, return to IDLE in the same edge; otherwise cnt+1.
REQ-017 Stop sample 1 with rx_valid=0 or rx_ready=1: rx_data <= shift_reg, rx_valid <= 1 in that edge.
REQ-018 Stop sample 1 with rx_valid=1 and rx_ready=0: overrun pulses 1 cycle; rx_data and rx_valid unchanged; new byte dropped.
REQ-019 Stop sample 0: frame_err pulses 1 cycle; byte discarded; rx_valid/rx_data unchanged (rx_valid still clears on rx_ready=1).
REQ-020 rx_valid=1 and rx_ready=1 with no completing byte: rx_valid <= 0 next edge; rx_data held.
REQ-021 Latency: with rx first low after edge E0, rx_valid rises at edge E0+3+HALF+9*CLKS_PER_BIT (E0+12 for CLKS_PER_BIT=1).
REQ-022 Back-to-back frames, no idle gap, SHALL be received without loss.
REQ-023 rx_valid, rx_data, frame_err, overrun SHALL depend only on registered state (no rx-to-output combinational path).

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state=IDLE, cnt=0, bit_idx=0, shift_reg=0, synchronizer flops=1, rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; a frame starting after release SHALL be received normally.

Verification
REQ-026 CLKS_PER_BIT=1, frame 0xA5 -> rx_data=0xA5, rx_valid high at E0+12, frame_err=0, overrun=0.
REQ-027 CLKS_PER_BIT=1, back-to-back 0xA5 then 0x3C, rx_ready=1 -> two single-cycle rx_valid transfers, 0xA5 then 0x3C, no overrun.
REQ-028 rx_ready=0, frames 0xA5 then 0x3C -> rx_data stays 0xA5, rx_valid stays 1, overrun pulses once at second stop sample.
REQ-029 Frame 0x55 with stop bit driven 0 -> frame_err 1-cycle pulse, rx_valid stays 0, busy falls next cycle.
REQ-030 CLKS_PER_BIT=16: 3-cycle low glitch -> busy rises then falls, no rx_valid; then frame 0x3C at 16 clk/bit -> rx_data=0x3C.
REQ-031 rst_n pulsed low during DATA of frame 0xFF -> all outputs 0 immediately; following frame 0x81 -> rx_data=0x81, rx_valid=1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// one-entry holding register with valid/ready handshake.
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   // state | meaning
   // IDLE  | line idle, waiting for rx_s low
   // START | counting to mid start bit to confirm it is not a glitch
   // DATA  | sampling 8 data bits, LSB first, one per CLKS_PER_BIT clocks
   // STOP  | waiting for mid stop bit, then deliver / flag the byte

   localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             rx_meta;
   logic             rx_s;

   // Synchronizer flops reset high so an idle line never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  busy <= 1'b1;
                  if (HALF == 0) begin
                     state   <= DATA;
                     cnt     <= '0;
                     bit_idx <= '0;
                  end else begin
                     state <= START;
                     cnt   <= CNT_W'(1);
                  end
               end
            end

            START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == CNT_LAST) begin
                  shift_reg[bit_idx] <= rx_s;
                  cnt                <= '0;
                  bit_idx            <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  // A full, unaccepted holding register wins: the new byte is dropped.
                  if (rx_s) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at 1 clk/bit, one at 16 clk/bit,
// exercised one at a time with directed and random 8N1 frames.
`timescale 1ns/1ps

module tb_uart_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n     [2];
   logic       rx        [2];
   logic       rx_ready  [2];
   logic [7:0] rx_data   [2];
   logic       rx_valid  [2];
   logic       busy      [2];
   logic       frame_err [2];
   logic       overrun   [2];

   uart_rx #(.CLKS_PER_BIT(1)) u_fast (
      .clk(clk), .rst_n(rst_n[0]), .rx(rx[0]), .rx_ready(rx_ready[0]),
      .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]),
      .frame_err(frame_err[0]), .overrun(overrun[0]));

   uart_rx #(.CLKS_PER_BIT(16)) u_slow (
      .clk(clk), .rst_n(rst_n[1]), .rx(rx[1]), .rx_ready(rx_ready[1]),
      .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]),
      .frame_err(frame_err[1]), .overrun(overrun[1]));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_fe   = 0;
   int exp_ov   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int last_e0  = 0;
   int rise_cyc [2];
   logic prev_valid [2];
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cpb(input int i);
      return (i == 0) ? 1 : 16;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected byte on every handshake, tallies pulses.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            prev_valid[i] = 1'b0;
         end else begin
            if (rx_valid[i] && !prev_valid[i])
               rise_cyc[i] = cyc;
            prev_valid[i] = rx_valid[i];
            if (rx_valid[i] && rx_ready[i]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: inst %0d got 0x%0h, expected no transfer", i, rx_data[i]);
               end else begin
                  check("rx_data", rx_data[i], exp_q.pop_front());
               end
            end
            if (frame_err[i]) begin
               fe_cnt++;
               check("busy_at_frame_err", busy[i], 0);
            end
            if (overrun[i]) begin
               ov_cnt++;
               check("valid_at_overrun", rx_valid[i], 1);
               if (exp_q.size() > 0)
                  check("data_at_overrun", rx_data[i], exp_q[0]);
            end
         end
      end
   end

   // Called just after a posedge; returns just after the posedge ending the stop bit.
   // Ready and the model update happen early in the data bits, after the previous
   // frame's stop sample, so that the stop decision sees this frame's ready.
   task automatic send_frame(input int i, input logic [7:0] d, input logic stop,
                             input logic rdy, input logic model);
      #1;
      rx[i]   = 1'b0;
      last_e0 = cyc;
      repeat (cpb(i)) @(posedge clk);
      for (int b = 0; b < 8; b++) begin
         #1;
         rx[i] = d[b];
         if (b == 2) begin
            rx_ready[i] = rdy;
            if (model) begin
               if (!stop)                        exp_fe++;
               else if (!rdy && exp_q.size() > 0) exp_ov++;
               else                              exp_q.push_back(d);
            end
         end
         repeat (cpb(i)) @(posedge clk);
      end
      #1;
      rx[i] = stop;
      repeat (cpb(i)) @(posedge clk);
   endtask

   task automatic idle(input int i, input int n);
      #1;
      rx[i] = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic drain();
      int k;
      #1;
      for (int i = 0; i < 2; i++) begin
         rx[i]       = 1'b1;
         rx_ready[i] = 1'b1;
      end
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(posedge clk);
         k++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      repeat (40) @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       saw_busy;
      logic [7:0] d;
      logic       st, rdy;

      for (int i = 0; i < 2; i++) begin
         rst_n[i]      = 1'b0;
         rx[i]         = 1'b1;
         rx_ready[i]   = 1'b0;
         prev_valid[i] = 1'b0;
         rise_cyc[i]   = 0;
      end
      #23;
      for (int i = 0; i < 2; i++) begin
         check("reset_rx_valid",  rx_valid[i],  0);
         check("reset_rx_data",   rx_data[i],   0);
         check("reset_busy",      busy[i],      0);
         check("reset_frame_err", frame_err[i], 0);
         check("reset_overrun",   overrun[i],   0);
      end
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      repeat (3) @(posedge clk);

      // Single frame: latency from first low rx to rx_valid rise.
      drain();
      send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1);
      idle(0, 10);
      check("latency_fast", rise_cyc[0] - last_e0, 3 + (cpb(0) - 1) / 2 + 9 * cpb(0));

      // Back-to-back frames with the consumer always ready.
      send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1);
      send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
      idle(0, 10);
      drain();

      // Consumer stalled: second byte must be dropped with an overrun pulse.
      send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1);
      send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1);
      idle(0, 10);
      check("stall_rx_valid", rx_valid[0], 1);
      check("stall_rx_data",  rx_data[0],  8'hA5);
      check("stall_overrun_count", ov_cnt, exp_ov);
      drain();

      // Bad stop bit.
      send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
      idle(0, 10);
      check("frame_err_rx_valid", rx_valid[0], 0);
      check("frame_err_count", fe_cnt, exp_fe);
      drain();

      // Random back-to-back traffic on the 1 clk/bit instance.
      for (int n = 0; n < 40; n++) begin
         d   = 8'($urandom);
         rdy = 1'($urandom_range(0, 1));
         st  = ($urandom_range(0, 5) != 0);
         send_frame(0, d, st, rdy, 1'b1);
      end
      idle(0, 10);
      drain();

      // 16 clk/bit: short glitch must be rejected.
      #1;
      rx[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx[1] = 1'b1;
      saw_busy = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy[1]) saw_busy = 1'b1;
      end
      @(posedge clk);
      check("glitch_busy_seen", saw_busy, 1);
      check("glitch_busy_end",  busy[1],  0);
      check("glitch_no_valid",  rx_valid[1], 0);

      send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
      idle(1, 30);
      check("slow_rx_data", rx_data[1], 8'h3C);
      check("latency_slow", rise_cyc[1] - last_e0, 3 + (cpb(1) - 1) / 2 + 9 * cpb(1));

      for (int n = 0; n < 8; n++) begin
         d   = 8'($urandom);
         rdy = 1'($urandom_range(0, 1));
         send_frame(1, d, 1'b1, rdy, 1'b1);
      end
      idle(1, 30);
      drain();

      // Reset in the middle of a frame while a byte is still held.
      send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
      idle(1, 30);
      check("pre_reset_valid", rx_valid[1], 1);
      fork
         send_frame(1, 8'hFF, 1'b1, 1'b0, 1'b0);
         begin
            repeat (80) @(posedge clk);
            #3;
            rst_n[1] = 1'b0;
            exp_q.delete();
            #1;
            check("midreset_rx_valid",  rx_valid[1],  0);
            check("midreset_rx_data",   rx_data[1],   0);
            check("midreset_busy",      busy[1],      0);
            check("midreset_frame_err", frame_err[1], 0);
            check("midreset_overrun",   overrun[1],   0);
         end
      join
      idle(1, 5);
      #1;
      rst_n[1] = 1'b1;
      repeat (3) @(posedge clk);
      send_frame(1, 8'h81, 1'b1, 1'b1, 1'b1);
      idle(1, 30);
      check("post_reset_rx_data", rx_data[1], 8'h81);
      drain();

      check("total_frame_err", fe_cnt, exp_fe);
      check("total_overrun",   ov_cnt, exp_ov);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
